// File: rtl/median_calc_pkg.sv
// -----------------------------------------------------------------------------
// median_calc_pkg
// Shared types and constants for the KxK rank-select (median) calculator.
//   state_t       : controller states IDLE / CALC / DONE
//   DEFAULT_*     : default pixel width and window side
//   default_rank  : rank of the (lower) median for an N-element window
// -----------------------------------------------------------------------------
package median_calc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_K      = 9;

   // Lower median for even N.
   function automatic int default_rank(input int n);
      return (n - 1) / 2;
   endfunction

endpackage : median_calc_pkg

// File: rtl/median_zero_counter.sv
// -----------------------------------------------------------------------------
// median_zero_counter
// Combinational popcount of still-live candidates whose bit b is zero.
//   window_i  : N pixels, element j at [j*DATA_W +: DATA_W]
//   mask_i    : live-candidate mask, one bit per element
//   bit_i     : bit index b under examination
//   plane_o   : bit b of every element (shared with the mask update)
//   c0_o      : count of j with mask_i[j] & ~pixel[j][b], RANK_W+1 bits
// -----------------------------------------------------------------------------
module median_zero_counter #(
   parameter int N      = 81,
   parameter int DATA_W = 8,
   localparam int RANK_W = $clog2(N),
   localparam int BIT_W  = $clog2(DATA_W)
) (
   input  logic [N*DATA_W-1:0] window_i,
   input  logic [N-1:0]        mask_i,
   input  logic [BIT_W-1:0]    bit_i,
   output logic [N-1:0]        plane_o,
   output logic [RANK_W:0]     c0_o
);

   logic [DATA_W-1:0] pix [N];

   for (genvar j = 0; j < N; j++) begin : g_unpack
      assign pix[j]     = window_i[j*DATA_W +: DATA_W];
      assign plane_o[j] = pix[j][bit_i];
   end

   // NOTE: every variable written in always_comb is given a value before any
   // conditional use, otherwise synthesis infers a latch.
   always_comb begin
      c0_o = '0;
      for (int j = 0; j < N; j++) begin
         c0_o = c0_o + {{RANK_W{1'b0}}, mask_i[j] & ~plane_o[j]};
      end
   end

endmodule : median_zero_counter

// File: rtl/median_filter_kxk_rank_calc.sv
// -----------------------------------------------------------------------------
// median_filter_kxk_rank_calc
// Selects the element of a given rank from a KxK window using MSB-first radix
// selection: one result bit per clock, DATA_W clocks per window.
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active-low
//   done_i    : window-valid strobe, sampled only in IDLE
//   window_i  : N*DATA_W flattened window, element 0 = top-left, row-major
//   rank_i    : requested rank, 0 = minimum (only with MEDIAN_CALC_RANK_SEL_EN)
//   busy_o    : high while a window is in progress
//   median_o  : selected value, held until the next completion
//   done_o    : one-cycle completion pulse
// Build option: define MEDIAN_CALC_RANK_SEL_EN to add rank_i (clamped to N-1);
// otherwise the rank is fixed at the median (N-1)/2.
// -----------------------------------------------------------------------------
module median_filter_kxk_rank_calc
   import median_calc_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int K      = DEFAULT_K
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     done_i,
   input  logic [K*K*DATA_W-1:0]    window_i,
`ifdef MEDIAN_CALC_RANK_SEL_EN
   input  logic [$clog2(K*K)-1:0]   rank_i,
`endif
   output logic                     busy_o,
   output logic [DATA_W-1:0]        median_o,
   output logic                     done_o
);

   localparam int N      = K * K;
   localparam int RANK_W = $clog2(N);
   localparam int BIT_W  = $clog2(DATA_W);

   state_t              state_q,  state_d;
   logic [N*DATA_W-1:0] win_q,    win_d;
   logic [N-1:0]        mask_q,   mask_d;
   logic [RANK_W:0]     rank_q,   rank_d;
   logic [BIT_W-1:0]    bit_q,    bit_d;
   logic [DATA_W-1:0]   res_q,    res_d;
   logic [DATA_W-1:0]   median_q, median_d;
   logic                done_q,   done_d;

   logic [RANK_W:0]     c0;
   logic [N-1:0]        plane;
   logic [RANK_W:0]     rank_load;
   logic                take_one;

   median_zero_counter #(
      .N      (N),
      .DATA_W (DATA_W)
   ) u_zero_counter (
      .window_i (win_q),
      .mask_i   (mask_q),
      .bit_i    (bit_q),
      .plane_o  (plane),
      .c0_o     (c0)
   );

`ifdef MEDIAN_CALC_RANK_SEL_EN
   // Out-of-range ranks saturate to the maximum element.
   assign rank_load = (int'(rank_i) >= N) ? (RANK_W+1)'(N - 1) : {1'b0, rank_i};
`else
   assign rank_load = (RANK_W+1)'(default_rank(N));
`endif

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      mask_d   = mask_q;
      rank_d   = rank_q;
      bit_d    = bit_q;
      res_d    = res_q;
      median_d = median_q;
      done_d   = 1'b0;
      take_one = 1'b0;

      case (state_q)
         IDLE: begin
            if (done_i) begin
               state_d = CALC;
               win_d   = window_i;
               mask_d  = '1;
               rank_d  = rank_load;
               bit_d   = BIT_W'(DATA_W - 1);
               res_d   = '0;
            end
         end

         CALC: begin
            // Fewer zeros than the remaining rank: the answer lies among the
            // ones, skipping past all the zeros below it.
            take_one     = (rank_q >= c0);
            res_d[bit_q] = take_one;
            if (take_one) begin
               rank_d = rank_q - c0;
            end
            mask_d = mask_q & (take_one ? plane : ~plane);
            if (bit_q == '0) begin
               state_d  = DONE;
               median_d = res_d;
               done_d   = 1'b1;
            end else begin
               bit_d = bit_q - 1'b1;
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all flops sample
   // the same pre-edge values; the window copy is reset along with the rest.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         win_q    <= '0;
         mask_q   <= '0;
         rank_q   <= '0;
         bit_q    <= '0;
         res_q    <= '0;
         median_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         mask_q   <= mask_d;
         rank_q   <= rank_d;
         bit_q    <= bit_d;
         res_q    <= res_d;
         median_q <= median_d;
         done_q   <= done_d;
      end
   end

   assign busy_o   = (state_q != IDLE);
   assign median_o = median_q;
   assign done_o   = done_q;

endmodule : median_filter_kxk_rank_calc

// File: tb/tb_median_filter_kxk_rank_calc.sv
// -----------------------------------------------------------------------------
// tb_median_filter_kxk_rank_calc
// Bench for the rank-select calculator: one K=3 and one K=9 instance, expected
// values from a sorting model pushed to per-instance queues at acceptance and
// popped when done_o is seen.
// -----------------------------------------------------------------------------
module tb_median_filter_kxk_rank_calc;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic            done_i3 = 1'b0;
   logic [9*8-1:0]  window3 = '0;
   logic            busy3, done3;
   logic [7:0]      median3;

   logic            done_i9 = 1'b0;
   logic [81*8-1:0] window9 = '0;
   logic            busy9, done9;
   logic [7:0]      median9;

`ifdef MEDIAN_CALC_RANK_SEL_EN
   logic [3:0]      rank3 = 4'd4;
   logic [6:0]      rank9 = 7'd40;
`endif

   median_filter_kxk_rank_calc #(.DATA_W(8), .K(3)) u_dut3 (
      .clk      (clk),
      .rst      (rst),
      .done_i   (done_i3),
      .window_i (window3),
`ifdef MEDIAN_CALC_RANK_SEL_EN
      .rank_i   (rank3),
`endif
      .busy_o   (busy3),
      .median_o (median3),
      .done_o   (done3)
   );

   median_filter_kxk_rank_calc #(.DATA_W(8), .K(9)) u_dut9 (
      .clk      (clk),
      .rst      (rst),
      .done_i   (done_i9),
      .window_i (window9),
`ifdef MEDIAN_CALC_RANK_SEL_EN
      .rank_i   (rank9),
`endif
      .busy_o   (busy9),
      .median_o (median9),
      .done_o   (done9)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [7:0] exp_q3 [$];
   logic [7:0] exp_q9 [$];
   int         done_times [$];
   logic [7:0] pix9 [81];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] model_rank(input logic [7:0] a [81], input int n, input int rank);
      logic [7:0] s [81];
      logic [7:0] t;
      int         r;
      s = a;
      for (int i = 0; i < n - 1; i++)
         for (int j = 0; j < n - 1 - i; j++)
            if (s[j] > s[j+1]) begin
               t = s[j]; s[j] = s[j+1]; s[j+1] = t;
            end
      r = (rank >= n) ? n - 1 : rank;
      return s[r];
   endfunction

   // Scoreboard pops on each completion pulse.
   always @(negedge clk) begin
      if (rst && done9) begin
         if (exp_q9.size() == 0) check("done9_unexpected", 1, 0);
         else                    check("median9", median9, exp_q9.pop_front());
         done_times.push_back(cyc);
      end
      if (rst && done3) begin
         if (exp_q3.size() == 0) check("done3_unexpected", 1, 0);
         else                    check("median3", median3, exp_q3.pop_front());
      end
   end

   task automatic pack9();
      for (int j = 0; j < 81; j++) window9[j*8 +: 8] = pix9[j];
   endtask

   function automatic int eff_rank(input int rank_req);
`ifdef MEDIAN_CALC_RANK_SEL_EN
      return rank_req;
`else
      return 40;
`endif
   endfunction

   // One K=9 window: accept, wait (bounded) for done, then confirm a single pulse.
   task automatic run9(input string tag, input int rank_req);
      bit seen;
`ifdef MEDIAN_CALC_RANK_SEL_EN
      rank9 = 7'(rank_req);
`endif
      pack9();
      exp_q9.push_back(model_rank(pix9, 81, eff_rank(rank_req)));
      done_i9 = 1'b1;
      @(posedge clk); #1;
      done_i9 = 1'b0;
      window9 = ~window9;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done9) seen = 1'b1;
      end
      check({tag, "_timeout"}, seen, 1);
      @(negedge clk);
      check({tag, "_single"}, done9, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] w3 [81];
      logic [7:0] vals3 [9];
      int busy_cnt, done_cnt, done_at, d;

      vals3 = '{8'd9, 8'd2, 8'd7, 8'd1, 8'd5, 8'd8, 8'd3, 8'd6, 8'd4};
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_busy9", busy9, 0);
      check("rst_done9", done9, 0);
      check("rst_median9", median9, 0);
      check("rst_busy3", busy3, 0);
      check("rst_median3", median3, 0);

      // K=3 window: latency, busy length, single pulse.
      @(posedge clk); #1;
      w3 = '{default: 8'd0};
      for (int j = 0; j < 9; j++) begin
         window3[j*8 +: 8] = vals3[j];
         w3[j] = vals3[j];
      end
      exp_q3.push_back(model_rank(w3, 9, 4));
      done_i3 = 1'b1;
      @(posedge clk); #1;
      done_i3 = 1'b0;
      window3 = '0;
      busy_cnt = 0; done_cnt = 0; done_at = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy3) busy_cnt++;
         if (done3) begin done_cnt++; done_at = i; end
      end
      check("k3_busy_cycles", busy_cnt, 9);
      check("k3_done_count", done_cnt, 1);
      check("k3_done_latency", done_at, 8);
      @(posedge clk); #1;

      for (int j = 0; j < 81; j++) pix9[j] = 8'hA5;
      run9("all_a5", 40);
      for (int j = 0; j < 81; j++) pix9[j] = 8'(80 - j);
      run9("reversed", 40);

      // Reset in the middle of CALC (bit 4 pending).
      for (int j = 0; j < 81; j++) pix9[j] = 8'(j);
      pack9();
      done_i9 = 1'b1;
      @(posedge clk); #1;
      done_i9 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_median", median9, 0);
      check("midrst_done", done9, 0);
      check("midrst_busy", busy9, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done9) done_cnt++;
      end
      check("midrst_no_done", done_cnt, 0);
      @(posedge clk); #1;
      run9("after_rst", 40);

      for (int j = 0; j < 81; j++) pix9[j] = (j % 2 == 0) ? 8'd255 : 8'd0;
      run9("41x255", 40);
      for (int j = 0; j < 81; j++) pix9[j] = (j % 2 == 0) ? 8'd0 : 8'd255;
      run9("41x0", 40);

      // done_i held high, window changing every cycle: accepts every 10 cycles.
      done_times.delete();
      done_i9 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         for (int j = 0; j < 81; j++) pix9[j] = 8'($urandom_range(0, 255));
         pack9();
         @(posedge clk);
         if (c % 10 == 0) exp_q9.push_back(model_rank(pix9, 81, 40));
         #1;
      end
      done_i9 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("stream_done_count", done_times.size(), 4);
      for (int i = 1; i < done_times.size(); i++) begin
         d = done_times[i] - done_times[i-1];
         check("stream_spacing", d, 10);
      end

`ifdef MEDIAN_CALC_RANK_SEL_EN
      for (int j = 0; j < 81; j++) pix9[j] = 8'((j * 7) % 81);
      run9("rank0", 0);
      run9("rank80", 80);
      run9("rank100", 100);
      run9("rank20", 20);
`endif

      repeat (2) @(posedge clk);
      check("queue9_empty", exp_q9.size(), 0);
      check("queue3_empty", exp_q3.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_median_filter_kxk_rank_calc

// File: doc/median_filter_kxk_rank_calc.md
Name: median_filter_kxk_rank_calc

Overview:
- Parametrised successor to the fixed 9x9 median calculator.
- Accepts one KxK window of DATA_W-bit pixels on a flattened bus and selects the element of a given rank (default: the median).
- Uses MSB-first radix selection: one bit resolved per clock, so the comparator network shrinks to one popcount.
- Sits between the line-buffer/window generator and the output pixel stage of the median filter path.

Parameters:
- DATA_W, 8, pixel width in bits (>=2).
- K, 9, window side; N = K*K elements (K>=2).
- RANK_W, $clog2(K*K), width of the rank index (derived localparam; not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- done_i  in  1  window-valid strobe; sampled only in IDLE.
- window_i  in  N*DATA_W  window; element j at bits [j*DATA_W +: DATA_W], j=0 is top-left (S1), row-major.
- rank_i  in  RANK_W  requested rank, 0 = minimum (present only with RANK_SEL_EN).
- busy_o  out  1  high while a window is in progress (state != IDLE).
- median_o  out  DATA_W  selected value; holds until the next completion.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, async): state=IDLE, median_o=0, done_o=0, busy_o=0, internal mask/registers cleared. Reset mid-CALC abandons the window; no done_o is produced.
- States: IDLE, CALC, DONE.
- IDLE -> CALC when done_i=1 at a rising edge. On that edge (acceptance edge A):
  - latch window_i into a copy register;
  - set the candidate mask to all-ones (N bits);
  - load the rank register r;
  - set bit index b = DATA_W-1.
- CALC, each edge:
  - c0 = count of candidates with bit b == 0.
  - If r < c0: result bit b = 0; clear candidates whose bit b == 1.
  - Else: result bit b = 1; r <= r - c0; clear candidates whose bit b == 0.
  - Decrement b.
  - On the edge processing b=0, go to DONE, load median_o with the full result and set done_o=1.
- DONE: done_o high for exactly one cycle (edge A+DATA_W through A+DATA_W+1), then IDLE. done_i is ignored in CALC and DONE.
- Latency and throughput:
  - done_o is visible in the cycle after edge A+DATA_W.
  - Earliest next acceptance is edge A+DATA_W+2.
  - Throughput is 1 window per DATA_W+2 cycles.
- Changes on window_i or rank_i after acceptance do not affect the result in progress.
- Widths:
  - c0 and r are RANK_W+1 bits; no overflow is possible because r < N holds invariant.
  - The candidate set is never empty, and duplicate values are handled naturally.
- Default rank is (N-1)/2; for even N this gives the lower median.

Optional Feature:
- Macro: MEDIAN_CALC_RANK_SEL_EN.
- Defined: rank_i port exists and is sampled at the acceptance edge. Any rank_i >= N is clamped to N-1, so the block returns the maximum. This allows min/max/percentile (morphological) filters from the same block.
- Undefined: rank_i is absent and the rank is the constant (N-1)/2.

Decomposition:
- Package median_calc_pkg holds:
  - the state typedef (IDLE/CALC/DONE);
  - default DATA_W and K constants;
  - a default-rank function (N-1)/2.
- Sub-module median_zero_counter: combinational popcount over N of (mask[j] & ~pixel[j][b]). Outputs c0 at RANK_W+1 bits, parametrised by N and DATA_W.

Test Plan:
- K=3, DATA_W=8, window {9,2,7,1,5,8,3,6,4}, done_i one cycle -> done_o pulses once, 8 cycles after the acceptance edge; median_o=5; busy_o high for exactly 9 cycles.
- K=9, all 81 elements 0xA5 -> median_o=0xA5, done_o single pulse.
- K=9, elements 0..80 in reversed order -> median_o=40. Then 41x 255 with 40x 0 -> 255; 41x 0 with 40x 255 -> 0.
- K=9, done_i held high with window_i changing every cycle -> acceptances exactly 10 cycles apart; each result matches the window present at its acceptance edge.
- rst driven low during CALC (bit 4) -> median_o=0 and done_o=0 immediately; no done_o after release; next window completes normally.
- With MEDIAN_CALC_RANK_SEL_EN, K=9, values 0..80:
  - rank_i=0 -> 0;
  - rank_i=80 -> 80;
  - rank_i=100 -> 80 (clamped);
  - rank_i=20 -> 20.
